// File: rtl/ones_mod_sched.sv
// ones_mod_sched: round-robin scheduler sharing one serial ones-count-mod-MOD detector
// among NREQ requesters; results are tagged with the granted requester id.
module ones_mod_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int MOD   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     data,
   input  logic                      flush,
   output logic [NREQ-1:0]           gnt,
   output logic                      busy,
   output logic                      done,
   output logic [$clog2(NREQ)-1:0]   done_id,
   output logic [$clog2(MOD)-1:0]    ones_mod,
   output logic                      detected
);
   localparam int IW = $clog2(NREQ);
   localparam int RW = $clog2(MOD);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state_q;
   logic [IW-1:0]    ptr_q, id_q, win, done_id_q;
   logic [WIDTH-1:0] sreg_q, word;
   logic [CW-1:0]    cnt_q;
   logic [RW-1:0]    res_q, res_d, ones_mod_q;
   logic [NREQ-1:0]  gnt_q;
   logic             found, done_q, det_q;
   // Winner is the first set request at or after the pointer, wrapping.
   always_comb begin
      int j;
      j = 0;
      win = '0;
      word = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr_q) + k) % NREQ;
         if (!found && req[j]) begin
            found = 1'b1;
            win = IW'(j);
            word = data[j*WIDTH +: WIDTH];
         end
      end
      res_d = !sreg_q[WIDTH-1] ? res_q : (res_q == RW'(MOD - 1)) ? '0 : res_q + 1'b1;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         id_q       <= '0;
         sreg_q     <= '0;
         cnt_q      <= '0;
         res_q      <= '0;
         gnt_q      <= '0;
         done_q     <= 1'b0;
         done_id_q  <= '0;
         ones_mod_q <= '0;
         det_q      <= 1'b0;
      end else begin
         gnt_q  <= '0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (found && !flush) begin
               gnt_q   <= NREQ'(1) << win;
               sreg_q  <= word;
               cnt_q   <= CW'(WIDTH);
               res_q   <= '0;
               id_q    <= win;
               ptr_q   <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
               state_q <= SHIFT;
            end
            SHIFT: if (flush) state_q <= IDLE;
            else begin
               sreg_q <= sreg_q << 1;
               cnt_q  <= cnt_q - 1'b1;
               res_q  <= res_d;
               if (cnt_q == CW'(1)) begin
                  done_q     <= 1'b1;
                  done_id_q  <= id_q;
                  ones_mod_q <= res_d;
                  det_q      <= (res_d == '0);
                  state_q    <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign gnt      = gnt_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign done_id  = done_id_q;
   assign ones_mod = ones_mod_q;
   assign detected = det_q;
endmodule

// File: tb/tb_ones_mod_sched.sv
// tb_ones_mod_sched: directed checks of grant order, serial residue results,
// latency, flush and async reset for ones_mod_sched (NREQ=4, WIDTH=8, MOD=4).
module tb_ones_mod_sched;
   localparam int NREQ = 4, WIDTH = 8, MOD = 4;
   logic            clk = 1'b0, reset = 1'b1, flush = 1'b0;
   logic [3:0]      req = '0;
   logic [31:0]     data = '0;
   logic [3:0]      gnt;
   logic            busy, done, detected;
   logic [1:0]      done_id, ones_mod;
   int              tests = 0, fails = 0, cyc = 0;
   int              c0, c1;

   ones_mod_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .MOD(MOD)) dut (
      .clk(clk), .reset(reset), .req(req), .data(data), .flush(flush),
      .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
      .ones_mod(ones_mod), .detected(detected)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_gnt(output int gc);
      int n;
      n = 0;
      while (gnt == 0 && n < 30) begin
         tick();
         n++;
      end
      chk("gnt_seen", int'(gnt != 0), 1);
      chk("gnt_onehot", int'($onehot(gnt)), 1);
      gc = cyc;
   endtask

   task automatic job(input int id, input int m, output int gc);
      int n;
      wait_gnt(gc);
      chk("gnt_id", gnt, 1 << id);
      n = 0;
      do begin
         tick();
         n++;
         if (gnt != 0) chk("gnt_pulse", gnt, 0);
      end while (!done && n < 40);
      chk("done_lat", n, WIDTH);
      chk("done_id", done_id, id);
      chk("ones_mod", ones_mod, m);
      chk("detected", detected, int'(m == 0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_det", detected, 0);
      chk("rst_id", done_id, 0);
      tick();
      reset = 1'b0;
      // single job, then done drops and results hold
      data[7:0] = 8'hF0;
      req = 4'b0001;
      job(0, 0, c0);
      req = '0;
      tick();
      chk("done_pulse", done, 0);
      chk("busy_idle", busy, 0);
      chk("hold_det", detected, 1);
      // residue patterns
      data[7:0] = 8'hB5;
      req = 4'b0001;
      job(0, 1, c0);
      data[7:0] = 8'hFF;
      job(0, 0, c0);
      data[7:0] = 8'h00;
      job(0, 0, c0);
      req = '0;
      // round robin from a fresh pointer, 10-cycle job period
      do_reset();
      data = {8'h0F, 8'h07, 8'h03, 8'h01};
      req = 4'b1111;
      job(0, 1, c0);
      job(1, 2, c1);
      chk("period", c1 - c0, WIDTH + 2);
      job(2, 3, c0);
      job(3, 0, c1);
      job(0, 1, c0);
      chk("period_wrap", c0 - c1, WIDTH + 2);
      // pointer order after grant to 2, and skipping a dropped request
      req = 4'b0100;
      job(2, 3, c0);
      req = 4'b1011;
      job(3, 0, c0);
      job(0, 1, c0);
      req = 4'b1001;
      job(3, 0, c0);
      // flush on the third SHIFT cycle
      data[15:8] = 8'hE0;
      req = 4'b0010;
      wait_gnt(c0);
      chk("fl_gnt", gnt, 4'b0010);
      req = '0;
      tick();
      tick();
      flush = 1'b1;
      tick();
      chk("fl_busy", busy, 0);
      chk("fl_done", done, 0);
      chk("fl_id", done_id, 3);
      chk("fl_mod", ones_mod, 0);
      // flush in IDLE blocks grants
      req = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fl_block", gnt, 0);
      end
      chk("fl_nodone", done, 0);
      flush = 1'b0;
      job(2, 3, c0);
      // async reset mid-SHIFT, then pointer restarts at 0
      wait_gnt(c0);
      chk("rs_gnt", gnt, 4'b1000);
      tick();
      tick();
      chk("rs_busy_pre", busy, 1);
      reset = 1'b1;
      #1;
      chk("rs_busy", busy, 0);
      chk("rs_gnt0", gnt, 0);
      chk("rs_done", done, 0);
      chk("rs_det", detected, 0);
      chk("rs_mod", ones_mod, 0);
      tick();
      reset = 1'b0;
      job(0, 1, c0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
